// File: rtl/eth_tx_pkg.sv
// Shared state type, framing constants and GMII beat payload for the transmit path.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        IFG      = 2'd3
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
    localparam logic [7:0]  SFD_BYTE           = 8'hD5;
    localparam int unsigned PREAMBLE_LEN       = 8;
    localparam int unsigned DEFAULT_IFG_CYCLES = 12;

    // One GMII transmit beat.
    typedef struct packed {
        logic       en;
        logic [7:0] txd;
    } gmii_tx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, contention goes to the
// source that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Arbitrates two frame sources onto one GMII transmit stream, inserting the
// preamble/SFD and enforcing the inter-frame gap.
module gmii_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = DEFAULT_IFG_CYCLES
) (
    input  logic       gmii_tx_clk,
    input  logic       tx_reset,
    input  logic       s0_req,
    input  logic       s1_req,
    input  logic [7:0] s0_txd,
    input  logic [7:0] s1_txd,
    input  logic       s0_valid,
    input  logic       s1_valid,
    input  logic       s0_last,
    input  logic       s1_last,
    output logic       s0_ready,
    output logic       s1_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       busy,
    output logic       grant_id,
    output logic       underrun_err
);

    localparam int unsigned PRE_CW = $clog2(PREAMBLE_LEN);
    localparam int unsigned IFG_CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    tx_state_e         state;
    tx_state_e         state_next;
    logic [PRE_CW-1:0] pre_cnt;
    logic [PRE_CW-1:0] pre_cnt_next;
    logic [IFG_CW-1:0] ifg_cnt;
    logic [IFG_CW-1:0] ifg_cnt_next;
    logic              grant_q;
    logic              grant_next;
    gmii_tx_t          tx_q;
    gmii_tx_t          tx_next;
    logic              underrun_q;
    logic              underrun_next;

    logic              any_req;
    logic              arb_grant;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_txd;
    logic              pre_done;

    rr_arb2 u_rr_arb2 (
        .req        ({s1_req, s0_req}),
        .last_grant (grant_q),
        .grant      (arb_grant)
    );

    assign any_req   = s0_req | s1_req;
    assign sel_valid = grant_q ? s1_valid : s0_valid;
    assign sel_last  = grant_q ? s1_last  : s0_last;
    assign sel_txd   = grant_q ? s1_txd   : s0_txd;
    // pre_cnt counts preamble bytes already scheduled; the SFD follows the seventh.
    assign pre_done  = (pre_cnt == PRE_CW'(PREAMBLE_LEN - 1));

    // State and registered outputs.
    always_ff @(posedge gmii_tx_clk) begin
        if (tx_reset) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            ifg_cnt    <= '0;
            grant_q    <= 1'b1;
            tx_q       <= '0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_next;
            pre_cnt    <= pre_cnt_next;
            ifg_cnt    <= ifg_cnt_next;
            grant_q    <= grant_next;
            tx_q       <= tx_next;
            underrun_q <= underrun_next;
        end
    end

    // Next-state, counters and grant.
    always_comb begin
        state_next   = state;
        pre_cnt_next = pre_cnt;
        ifg_cnt_next = ifg_cnt;
        grant_next   = grant_q;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next   = PREAMBLE;
                    pre_cnt_next = PRE_CW'(1);
                    grant_next   = arb_grant;
                end
            end
            PREAMBLE: begin
                if (pre_done) begin
                    state_next   = PAYLOAD;
                    pre_cnt_next = '0;
                end else begin
                    pre_cnt_next = pre_cnt + PRE_CW'(1);
                end
            end
            PAYLOAD: begin
                // Either the final byte or a missing byte ends the frame.
                if (!sel_valid || sel_last) begin
                    state_next   = IFG;
                    ifg_cnt_next = '0;
                end
            end
            IFG: begin
                if (ifg_cnt == IFG_CW'(IFG_CYCLES - 1)) begin
                    state_next   = IDLE;
                    ifg_cnt_next = '0;
                end else begin
                    ifg_cnt_next = ifg_cnt + IFG_CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next GMII beat and abort pulse; idle beats are all-zero.
    always_comb begin
        tx_next       = '0;
        underrun_next = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    tx_next.en  = 1'b1;
                    tx_next.txd = PREAMBLE_BYTE;
                end
            end
            PREAMBLE: begin
                tx_next.en  = 1'b1;
                tx_next.txd = pre_done ? SFD_BYTE : PREAMBLE_BYTE;
            end
            PAYLOAD: begin
                if (sel_valid) begin
                    tx_next.en  = 1'b1;
                    tx_next.txd = sel_txd;
                end else begin
                    underrun_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign s0_ready     = (state == PAYLOAD) && !grant_q;
    assign s1_ready     = (state == PAYLOAD) &&  grant_q;
    assign gmii_txd     = tx_q.txd;
    assign gmii_tx_en   = tx_q.en;
    assign busy         = (state != IDLE);
    assign grant_id     = grant_q;
    assign underrun_err = underrun_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: scenario table, reset-truncation sequence and
// randomized traffic, all checked cycle by cycle against a frame-level model.
module tb_gmii_tx_arbiter;

    localparam int IFG     = 12;
    localparam int PH_IDLE = 0;
    localparam int PH_GAP  = 1;
    localparam int PH_REQ  = 2;
    localparam int PH_SEND = 3;

    logic       gmii_tx_clk;
    logic       tx_reset;
    logic       s0_req, s1_req, s0_valid, s1_valid, s0_last, s1_last;
    logic [7:0] s0_txd, s1_txd;
    logic       s0_ready, s1_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, busy, grant_id, underrun_err;

    gmii_tx_arbiter #(.IFG_CYCLES(IFG)) dut (
        .gmii_tx_clk  (gmii_tx_clk),
        .tx_reset     (tx_reset),
        .s0_req       (s0_req),
        .s1_req       (s1_req),
        .s0_txd       (s0_txd),
        .s1_txd       (s1_txd),
        .s0_valid     (s0_valid),
        .s1_valid     (s1_valid),
        .s0_last      (s0_last),
        .s1_last      (s1_last),
        .s0_ready     (s0_ready),
        .s1_ready     (s1_ready),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .busy         (busy),
        .grant_id     (grant_id),
        .underrun_err (underrun_err)
    );

    initial begin
        gmii_tx_clk = 1'b0;
        forever #5 gmii_tx_clk = ~gmii_tx_clk;
    end

    // und < 0 means the frame completes; otherwise valid drops after und bytes.
    typedef struct {
        int         len;
        int         und;
        logic [7:0] base;
        int         gap;
    } plan_t;

    typedef struct {
        int         len0;
        int         und0;
        int         n0;
        int         len1;
        int         und1;
        int         n1;
        int         exp_frames;
        logic [3:0] exp_gid;
        int         exp_run0;
        int         exp_run1;
        int         exp_gap;
        int         exp_und;
    } vec_t;

    int total;
    int bad;
    int cyc;
    bit chk_on;

    // Frame-level model of the arbiter.
    bit         m_act, m_und, m_grant, m_w;
    int         m_n, m_last_high, m_pay_end, m_free_at;
    logic [7:0] m_base;

    // Source drivers.
    plan_t q0[$];
    plan_t q1[$];
    plan_t cur[2];
    int    ph[2];
    int    cnt[2];
    int    gapc[2];

    // Output monitor.
    bit   prev_en, had_frame;
    int   hi_run, lo_run, und_cnt;
    int   runs[$];
    int   gaps[$];
    logic gids[$];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected {en, txd, ready0, ready1, busy, grant_id, underrun} in cycle t.
    function automatic logic [13:0] expect_at(input int t);
        logic       en, r0, r1, bz, und;
        logic [7:0] d;
        en = 1'b0; d = 8'h00; r0 = 1'b0; r1 = 1'b0; bz = 1'b0; und = 1'b0;
        if (m_act && t > m_n && t < m_free_at) begin
            bz = 1'b1;
            if (t <= m_n + 8) begin
                en = 1'b1;
                d  = (t == m_n + 8) ? 8'hD5 : 8'h55;
            end else if (t <= m_last_high) begin
                en = 1'b1;
                d  = m_base + 8'(t - m_n - 9);
            end
            if (t >= m_n + 8 && t <= m_pay_end) begin
                if (m_w) r1 = 1'b1;
                else     r0 = 1'b1;
            end
            und = m_und && (t == m_last_high + 1);
        end
        return {en, d, r0, r1, bz, m_grant, und};
    endfunction

    task automatic model_update(input int t);
        bit    w;
        plan_t p;
        int    b;
        if (tx_reset) begin
            m_act     = 1'b0;
            m_grant   = 1'b1;
            m_free_at = t + 1;
        end else if (t >= m_free_at && (s0_req || s1_req)) begin
            w         = (s0_req && s1_req) ? !m_grant : s1_req;
            p         = cur[w];
            m_und     = (p.und >= 0);
            b         = m_und ? p.und : p.len;
            m_act     = 1'b1;
            m_n       = t;
            m_w       = w;
            m_base    = p.base;
            m_grant   = w;
            m_last_high = t + 8 + b;
            m_pay_end = m_und ? t + 8 + p.und : t + 7 + p.len;
            // An aborted frame also spends its abort cycle before the gap.
            m_free_at = m_last_high + IFG + (m_und ? 1 : 0);
        end
    endtask

    task automatic bfm(input int s, input logic rdy, output logic req, output logic val,
                       output logic lst, output logic [7:0] d);
        int lim;
        req = 1'b0; val = 1'b0; lst = 1'b0; d = 8'h00;
        if (ph[s] == PH_IDLE) begin
            if (s == 0 && q0.size() > 0) begin
                cur[0] = q0.pop_front(); ph[0] = PH_GAP; gapc[0] = cur[0].gap;
            end else if (s == 1 && q1.size() > 0) begin
                cur[1] = q1.pop_front(); ph[1] = PH_GAP; gapc[1] = cur[1].gap;
            end
        end
        if (ph[s] == PH_GAP) begin
            if (gapc[s] == 0) ph[s] = PH_REQ;
            else              gapc[s]--;
        end
        if (ph[s] == PH_REQ && rdy === 1'b1) begin
            ph[s]  = PH_SEND;
            cnt[s] = 0;
        end
        req = (ph[s] == PH_REQ);
        if (ph[s] == PH_SEND) begin
            lim = (cur[s].und < 0) ? cur[s].len : cur[s].und;
            val = (cnt[s] < lim);
            if (val) begin
                d   = cur[s].base + 8'(cnt[s]);
                lst = (cur[s].und < 0) && (cnt[s] == cur[s].len - 1);
            end
            if (rdy === 1'b1) begin
                if (!val || lst) ph[s] = PH_IDLE;
                else             cnt[s]++;
            end
        end
    endtask

    task automatic monitor();
        if (gmii_tx_en === 1'b1) begin
            if (!prev_en) begin
                if (had_frame) gaps.push_back(lo_run);
                hi_run = 0;
                gids.push_back(grant_id);
            end
            hi_run++;
        end else begin
            if (prev_en) begin
                runs.push_back(hi_run);
                had_frame = 1'b1;
                lo_run    = 0;
            end
            lo_run++;
        end
        if (underrun_err === 1'b1) und_cnt++;
        prev_en = (gmii_tx_en === 1'b1);
    endtask

    task automatic clear_monitor();
        runs.delete(); gaps.delete(); gids.delete();
        prev_en = 1'b0; had_frame = 1'b0; hi_run = 0; lo_run = 0; und_cnt = 0;
    endtask

    // One clock: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input bit rst);
        logic       r0, v0, l0, r1, v1, l1;
        logic [7:0] d0, d1;
        logic [13:0] got, want;
        @(negedge gmii_tx_clk);
        cyc++;
        if (chk_on) begin
            got  = {gmii_tx_en, gmii_txd, s0_ready, s1_ready, busy, grant_id, underrun_err};
            want = expect_at(cyc);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cycle %0d outputs {en,txd,rdy0,rdy1,busy,gid,und}: got %b_%h_%b%b%b%b%b want %b_%h_%b%b%b%b%b",
                         cyc, got[13], got[12:5], got[4], got[3], got[2], got[1], got[0],
                         want[13], want[12:5], want[4], want[3], want[2], want[1], want[0]);
            end
        end
        monitor();
        if (rst) begin
            q0.delete(); q1.delete();
            ph[0] = PH_IDLE; ph[1] = PH_IDLE;
            r0 = 1'b0; v0 = 1'b0; l0 = 1'b0; d0 = 8'h00;
            r1 = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = 8'h00;
        end else begin
            bfm(0, s0_ready, r0, v0, l0, d0);
            bfm(1, s1_ready, r1, v1, l1, d1);
        end
        tx_reset = rst;
        s0_req = r0; s0_valid = v0; s0_last = l0; s0_txd = d0;
        s1_req = r1; s1_valid = v1; s1_last = l1; s1_txd = d1;
        model_update(cyc);
        if (rst) chk_on = 1'b1;
    endtask

    task automatic run_reset();
        step(1'b1);
        step(1'b1);
        clear_monitor();
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && ph[0] == PH_IDLE && ph[1] == PH_IDLE &&
                 cyc >= m_free_at + 2) && budget < 3000) begin
            step(1'b0);
            budget++;
        end
        check({name, " drained"}, int'(budget < 3000), 1);
    endtask

    function automatic plan_t mk_plan(input int len, input int und, input logic [7:0] base,
                                      input int gap);
        plan_t p;
        p.len = len; p.und = und; p.base = base; p.gap = gap;
        return p;
    endfunction

    vec_t tbl[6];

    initial begin
        int req_cyc;
        int budget;
        int len;

        // {len0,und0,n0, len1,und1,n1, frames, gid bits, run0, run1, gap, underruns}
        tbl[0] = '{60, -1, 1,  0, -1, 0, 1, 4'b0000, 68,  0,  0, 0};
        tbl[1] = '{46, -1, 1, 50, -1, 1, 2, 4'b0010, 54, 58, 12, 0};
        tbl[2] = '{ 0, -1, 0, 64, -1, 2, 2, 4'b0011, 72, 72, 12, 0};
        tbl[3] = '{64, 10, 2,  0, -1, 0, 2, 4'b0000, 18, 72, 13, 1};
        tbl[4] = '{20, -1, 2, 30, -1, 2, 4, 4'b1010, 28, 38, 12, 0};
        tbl[5] = '{ 0, -1, 0,  1,  0, 2, 2, 4'b0011,  8,  9, 13, 1};

        total = 0; bad = 0; cyc = 0; chk_on = 1'b0;
        m_act = 1'b0; m_und = 1'b0; m_grant = 1'b1; m_w = 1'b0;
        m_n = 0; m_last_high = 0; m_pay_end = 0; m_free_at = 0; m_base = 8'h00;
        ph[0] = PH_IDLE; ph[1] = PH_IDLE; cnt[0] = 0; cnt[1] = 0; gapc[0] = 0; gapc[1] = 0;
        tx_reset = 1'b1;
        s0_req = 1'b0; s0_valid = 1'b0; s0_last = 1'b0; s0_txd = 8'h00;
        s1_req = 1'b0; s1_valid = 1'b0; s1_last = 1'b0; s1_txd = 8'h00;
        clear_monitor();

        run_reset();
        step(1'b0);
        check("reset state", int'({gmii_tx_en, gmii_txd, s0_ready, s1_ready, busy, grant_id, underrun_err}),
              int'(14'b0_00000000_0_0_0_1_0));

        // Scenario table.
        for (int i = 0; i < 6; i++) begin
            run_reset();
            for (int k = 0; k < tbl[i].n0; k++)
                q0.push_back(mk_plan(tbl[i].len0, (k == 0) ? tbl[i].und0 : -1, 8'h00, 0));
            for (int k = 0; k < tbl[i].n1; k++)
                q1.push_back(mk_plan(tbl[i].len1, (k == 0) ? tbl[i].und1 : -1, 8'h80, 0));
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d frames", i), runs.size(), tbl[i].exp_frames);
            for (int f = 0; f < tbl[i].exp_frames && f < gids.size(); f++)
                check($sformatf("vec%0d grant[%0d]", i, f), int'(gids[f]), int'(tbl[i].exp_gid[f]));
            check($sformatf("vec%0d run0", i), (runs.size() > 0) ? runs[0] : -1, tbl[i].exp_run0);
            if (tbl[i].exp_frames >= 2) begin
                check($sformatf("vec%0d run1", i), (runs.size() > 1) ? runs[1] : -1, tbl[i].exp_run1);
                check($sformatf("vec%0d gap", i), (gaps.size() > 0) ? gaps[0] : -1, tbl[i].exp_gap);
            end
            check($sformatf("vec%0d underruns", i), und_cnt, tbl[i].exp_und);
        end

        // Reset in the middle of a payload, then a fresh s1 request.
        run_reset();
        q0.push_back(mk_plan(64, -1, 8'h10, 0));
        budget = 0;
        while (!(ph[0] == PH_SEND && cnt[0] == 20) && budget < 500) begin
            step(1'b0);
            budget++;
        end
        check("reach byte 20", int'(budget < 500), 1);
        step(1'b1);
        step(1'b0);
        check("mid reset tx_en", int'(gmii_tx_en), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset ready", int'({s0_ready, s1_ready}), 0);
        check("mid reset underrun", int'(underrun_err), 0);
        q1.push_back(mk_plan(5, -1, 8'hA0, 0));
        budget = 0;
        while (s1_req !== 1'b1 && budget < 50) begin
            step(1'b0);
            budget++;
        end
        req_cyc = cyc;
        budget = 0;
        while (gmii_tx_en !== 1'b1 && budget < 50) begin
            step(1'b0);
            budget++;
        end
        check("post reset preamble latency", cyc - req_cyc, 1);
        check("post reset grant", int'(grant_id), 1);
        check("post reset first byte", int'(gmii_txd), 8'h55);
        drain("post reset");

        // Randomized traffic with occasional resets.
        run_reset();
        for (int c = 0; c < 6000 && bad < 50; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(1, 40));
                q0.push_back(mk_plan(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                                     8'($urandom), int'($urandom_range(0, 15))));
            end
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(1, 40));
                q1.push_back(mk_plan(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                                     8'($urandom), int'($urandom_range(0, 15))));
            end
            step($urandom_range(0, 699) == 0);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
